flash_audio_addr_ctrl: RTL and testbench
========================================

Name: flash_audio_addr_ctrl

Overview:
Consumer of the 2-bit direction code from the keyboard FSM. It reads 32-bit words from the flash read port and emits one 16-bit audio sample per sample tick, two samples per word. It plays forward or backward and pauses according to direction, and sits between the keyboard FSM, the flash controller and the audio DAC path.

Parameters:
ADDR_W, 23, flash word-address width.
LAST_ADDR, 23'h7FFFF, highest word address of the audio clip; the clip spans 0..LAST_ADDR.

Ports:
clk  in  1  system clock, rising-edge.
reset_n  in  1  asynchronous active-low reset.
direction  in  2  bit1 = play (1) / pause (0); bit0 = forward (1) / backward (0). Sampled every clk.
restart  in  1  one-cycle pulse; jumps to start of clip for the current direction.
sample_tick  in  1  one-cycle strobe at the audio sample rate.
flash_read  out  1  read request to flash.
flash_address  out  ADDR_W  word address for flash_read.
flash_waitrequest  in  1  flash busy; hold the request while high.
flash_readdatavalid  in  1  flash_readdata is valid this cycle.
flash_readdata  in  32  word read from flash.
audio_data  out  16  current sample, two's complement.
audio_valid  out  1  one-cycle pulse when audio_data updates.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, flash_address=0, flash_read=0, audio_data=0, audio_valid=0, word register=0.
- States: IDLE, REQ, WAIT_DATA, WAIT_TICK_A, WAIT_TICK_B, ADVANCE.
- IDLE:
  - Go to REQ next cycle when direction[1]=1.
  - Otherwise stay in IDLE with outputs held.
- REQ:
  - flash_read=1 with flash_address stable.
  - Leave for WAIT_DATA on the first cycle flash_waitrequest=0.
  - flash_read drops in that same transition.
- WAIT_DATA:
  - Latch flash_readdata into the word register on flash_readdatavalid=1, then go to WAIT_TICK_A.
  - No timeout.
- WAIT_TICK_A:
  - On sample_tick with play=1: audio_data = first sample, audio_valid=1 for one cycle, go to WAIT_TICK_B.
  - First sample is readdata[15:0] when forward, readdata[31:16] when backward.
- WAIT_TICK_B:
  - On sample_tick with play=1: audio_data = the other half, audio_valid=1, go to ADVANCE.
- ADVANCE (one cycle):
  - Forward: address+1.
  - Backward: address-1.
  - Then go to REQ.
- Direction bit0 is sampled at the first-sample output and at ADVANCE, so a word is never split across directions mid-pair.
- Pause:
  - While direction[1]=0, ticks are ignored and audio_data and address are held.
  - An in-flight flash read still completes.
  - Playback resumes exactly where it stopped.
- Wrap:
  - Forward at LAST_ADDR goes to 0.
  - Backward at 0 goes to LAST_ADDR.
  - Address arithmetic is modulo LAST_ADDR+1, never exceeding LAST_ADDR.
- restart:
  - Takes priority over all transitions except reset.
  - Next cycle: address = 0 if forward, LAST_ADDR if backward.
  - State goes to REQ if play=1, else IDLE.
  - audio_data is held.
  - A pending flash_readdatavalid for the aborted read is discarded. Track one outstanding read and drop its data.
- Simultaneous restart and sample_tick: restart wins; no audio_valid.
- sample_tick arriving in REQ, WAIT_DATA or ADVANCE is dropped. There is no tick buffering; the flash is required to return data within one tick period.

Optional Feature:
Macro FLASH_AUDIO_ONESHOT_EN.
- Defined: no wrap. At the last word of the current direction (LAST_ADDR forward, 0 backward), after its second sample the block enters IDLE and stays there until restart. Play=1 alone does not resume.
- Undefined: endless wrap-around as described above.

Test Plan:
- Reset, then direction=2'b11, flash returns 32'hBBBB_AAAA at address 0 after 3 cycles, two ticks -> audio_data 16'hAAAA then 16'hBBBB, one audio_valid each; next flash_address=1.
- direction=2'b10 (backward) from address 5 with word 32'h2222_1111 -> output 16'h2222 then 16'h1111; next flash_address=4.
- Forward at LAST_ADDR -> next request at address 0. Backward at 0 -> next request at 23'h7FFFF. With FLASH_AUDIO_ONESHOT_EN -> IDLE, flash_read stays 0 for 100 cycles.
- Pause (2'b01) after the first sample, 10 ticks -> no audio_valid, audio_data and flash_address unchanged. Re-play -> second half of the same word is emitted next.
- restart during WAIT_DATA at address 0x1234, forward -> late readdatavalid ignored, flash_read asserted with address 0, no audio_valid that tick.
- reset_n low mid-REQ with flash_waitrequest=1 -> flash_read=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flash_audio_addr_ctrl_if.sv
// flash_audio_addr_ctrl_if: control, flash read port and audio output bundle of the audio address controller
interface flash_audio_addr_ctrl_if #(parameter int ADDR_W = 23);
   logic [1:0]        direction;
   logic              restart;
   logic              sample_tick;
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic              flash_waitrequest;
   logic              flash_readdatavalid;
   logic [31:0]       flash_readdata;
   logic [15:0]       audio_data;
   logic              audio_valid;
   modport master (
      input  direction, restart, sample_tick, flash_waitrequest, flash_readdatavalid, flash_readdata,
      output flash_read, flash_address, audio_data, audio_valid
   );
   modport slave (
      output direction, restart, sample_tick, flash_waitrequest, flash_readdatavalid, flash_readdata,
      input  flash_read, flash_address, audio_data, audio_valid
   );
endinterface

// File: rtl/flash_audio_addr_ctrl.sv
// flash_audio_addr_ctrl: walks flash words forward/backward and emits two 16-bit samples per word on sample ticks
// FLASH_AUDIO_ONESHOT_EN: when defined, playback stops in IDLE after the last word instead of wrapping
module flash_audio_addr_ctrl #(
   parameter int                ADDR_W    = 23,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
   input logic                    clk,
   input logic                    reset_n,
   flash_audio_addr_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, WAIT_TICK_A, WAIT_TICK_B, ADVANCE} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_read;
   logic [31:0]       r_word;
   logic [15:0]       r_audio;
   logic              r_valid;
   logic              r_fwd;
   logic [1:0]        r_pend;
   logic [1:0]        r_drop;
   logic              w_play;
   logic              w_fwd;
   logic              w_tick;
   logic              w_rdv;
   logic              w_accept;
   logic              w_drop_now;
   logic              w_stop;
   logic              w_go;
   logic [1:0]        w_pend_nxt;
   logic [ADDR_W-1:0] w_next_addr;
   assign w_play      = bus.direction[1];
   assign w_fwd       = bus.direction[0];
   assign w_tick      = bus.sample_tick && w_play;
   assign w_rdv       = bus.flash_readdatavalid;
   assign w_accept    = r_read && !bus.flash_waitrequest;
   assign w_drop_now  = w_rdv && (r_drop != 2'd0);
   assign w_pend_nxt  = r_pend + {1'b0, w_accept} - {1'b0, w_rdv};
   assign w_next_addr = w_fwd ? ((r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1)
                              : ((r_addr == '0) ? LAST_ADDR : r_addr - 1'b1);
`ifdef FLASH_AUDIO_ONESHOT_EN
   logic r_done;
   assign w_stop = w_fwd ? (r_addr == LAST_ADDR) : (r_addr == '0);
   assign w_go   = w_play && !r_done;
`else
   assign w_stop = 1'b0;
   assign w_go   = w_play;
`endif
   assign bus.flash_read    = r_read;
   assign bus.flash_address = r_addr;
   assign bus.audio_data    = r_audio;
   assign bus.audio_valid   = r_valid;
   // playback FSM; restart aborts everything and marks in-flight reads so their data is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_read  <= 1'b0;
         r_word  <= '0;
         r_audio <= '0;
         r_valid <= 1'b0;
         r_fwd   <= 1'b0;
         r_pend  <= '0;
         r_drop  <= '0;
`ifdef FLASH_AUDIO_ONESHOT_EN
         r_done  <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_pend  <= w_pend_nxt;
         r_drop  <= r_drop - {1'b0, w_drop_now};
         if (bus.restart) begin
            r_addr  <= w_fwd ? '0 : LAST_ADDR;
            r_state <= w_play ? REQ : IDLE;
            r_read  <= w_play;
            r_drop  <= w_pend_nxt;
`ifdef FLASH_AUDIO_ONESHOT_EN
            r_done  <= 1'b0;
`endif
         end else begin
            case (r_state)
               IDLE: if (w_go) begin
                  r_state <= REQ;
                  r_read  <= 1'b1;
               end
               REQ: if (w_accept) begin
                  r_state <= WAIT_DATA;
                  r_read  <= 1'b0;
               end
               WAIT_DATA: if (w_rdv && !w_drop_now) begin
                  r_word  <= bus.flash_readdata;
                  r_state <= WAIT_TICK_A;
               end
               WAIT_TICK_A: if (w_tick) begin
                  r_fwd   <= w_fwd;
                  r_audio <= w_fwd ? r_word[15:0] : r_word[31:16];
                  r_valid <= 1'b1;
                  r_state <= WAIT_TICK_B;
               end
               WAIT_TICK_B: if (w_tick) begin
                  r_audio <= r_fwd ? r_word[31:16] : r_word[15:0];
                  r_valid <= 1'b1;
                  r_state <= ADVANCE;
               end
               ADVANCE: begin
                  r_state <= w_stop ? IDLE : REQ;
                  r_read  <= !w_stop;
                  if (!w_stop) r_addr <= w_next_addr;
`ifdef FLASH_AUDIO_ONESHOT_EN
                  r_done  <= w_stop;
`endif
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_flash_audio_addr_ctrl.sv
// tb_flash_audio_addr_ctrl: directed bench with a flash model and a sample scoreboard
module tb_flash_audio_addr_ctrl;
   localparam logic [22:0] LAST = 23'h7FFFF;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 3;
   int wcnt = 0;
   bit wr_force = 1'b0;
   logic [15:0] exp_q[$];
   logic [22:0] pa[$];
   int          pt[$];
   logic [15:0] mon_e;
   flash_audio_addr_ctrl_if #(.ADDR_W(23)) bus ();
   flash_audio_addr_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] word(input logic [22:0] a);
      return (a == 23'd0) ? 32'hBBBB_AAAA : (a == 23'd5) ? 32'h2222_1111 : {~a[15:0], a[15:0]};
   endfunction
   assign bus.flash_waitrequest = wr_force || (bus.flash_read && wcnt < 2);
   // flash model: two wait cycles per request, data returned in order lat cycles after acceptance
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset_n) begin
         wcnt <= 0;
         pa.delete();
         pt.delete();
         bus.flash_readdatavalid <= 1'b0;
         bus.flash_readdata <= '0;
      end else begin
         wcnt <= (bus.flash_read && bus.flash_waitrequest) ? wcnt + 1 : 0;
         if (bus.flash_read && !bus.flash_waitrequest) begin
            pa.push_back(bus.flash_address);
            pt.push_back(cyc + lat);
         end
         if (pt.size() != 0 && pt[0] <= cyc) begin
            bus.flash_readdatavalid <= 1'b1;
            bus.flash_readdata <= word(pa[0]);
            void'(pa.pop_front());
            void'(pt.pop_front());
         end else bus.flash_readdatavalid <= 1'b0;
      end
   end
   // scoreboard: every audio_valid pulse must match the next expected sample
   always @(negedge clk) begin
      if (reset_n && bus.audio_valid) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_valid: audio_data=%h but no sample expected", bus.audio_data);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            assert (bus.audio_data === mon_e) else begin
               errors++;
               $error("FAIL sample: got %h expected %h", bus.audio_data, mon_e);
            end
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic wait_read(input logic [22:0] a, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = bus.flash_read;
      end
      chk({tag, "_req"}, {31'd0, seen}, 32'd1);
      chk({tag, "_addr"}, {9'd0, bus.flash_address}, {9'd0, a});
   endtask
   task automatic tick(input bit push, input logic [15:0] v);
      @(posedge clk);
      #1;
      if (push) exp_q.push_back(v);
      bus.sample_tick = 1'b1;
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
   endtask
   task automatic play_word(input logic [22:0] a, input bit fwd);
      logic [31:0] w;
      w = word(a);
      repeat (lat + 8) @(posedge clk);
      tick(1'b1, fwd ? w[15:0] : w[31:16]);
      repeat (2) @(posedge clk);
      tick(1'b1, fwd ? w[31:16] : w[15:0]);
   endtask
   task automatic pulse_restart(input bit with_tick);
      @(posedge clk);
      #1;
      bus.restart = 1'b1;
      bus.sample_tick = with_tick;
      @(posedge clk);
      #1;
      bus.restart = 1'b0;
      bus.sample_tick = 1'b0;
   endtask
   task automatic idle_check(input string tag);
      int hits = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.flash_read) hits++;
      end
      chk(tag, hits, 32'd0);
   endtask
   initial begin
      logic [31:0] w;
      bus.direction = 2'b00;
      bus.restart = 1'b0;
      bus.sample_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read", {31'd0, bus.flash_read}, 32'd0);
      chk("rst_addr", {9'd0, bus.flash_address}, 32'd0);
      chk("rst_data", {16'd0, bus.audio_data}, 32'd0);
      chk("rst_valid", {31'd0, bus.audio_valid}, 32'd0);
      reset_n = 1'b1;
      bus.direction = 2'b11;
      wait_read(23'd0, "fwd0");
      play_word(23'd0, 1'b1);
      for (int a = 1; a < 5; a++) begin
         wait_read(23'(a), "fwd");
         play_word(23'(a), 1'b1);
      end
      wait_read(23'd5, "fwd5");
      bus.direction = 2'b10;
      play_word(23'd5, 1'b0);
      wait_read(23'd4, "bwd4");
      w = word(23'd4);
      repeat (lat + 8) @(posedge clk);
      tick(1'b1, w[31:16]);
      bus.direction = 2'b01;
      for (int i = 0; i < 10; i++) tick(1'b0, 16'h0);
      chk("pause_addr", {9'd0, bus.flash_address}, 32'd4);
      chk("pause_data", {16'd0, bus.audio_data}, {16'd0, w[31:16]});
      chk("pause_read", {31'd0, bus.flash_read}, 32'd0);
      bus.direction = 2'b10;
      tick(1'b1, w[15:0]);
      wait_read(23'd3, "bwd3");
      lat = 8;
      repeat (4) @(posedge clk);
      #1;
      bus.direction = 2'b11;
      pulse_restart(1'b1);
      wait_read(23'd0, "restart");
      play_word(23'd0, 1'b1);
      wait_read(23'd1, "after_restart");
      lat = 3;
      bus.direction = 2'b10;
      pulse_restart(1'b0);
      wait_read(LAST, "restart_bwd");
      bus.direction = 2'b11;
      play_word(LAST, 1'b1);
`ifdef FLASH_AUDIO_ONESHOT_EN
      idle_check("oneshot_fwd_idle");
      pulse_restart(1'b0);
      wait_read(23'd0, "oneshot_restart");
      bus.direction = 2'b10;
      play_word(23'd0, 1'b0);
      idle_check("oneshot_bwd_idle");
`else
      wait_read(23'd0, "wrap_fwd");
      bus.direction = 2'b10;
      play_word(23'd0, 1'b0);
      wait_read(LAST, "wrap_bwd");
`endif
      wr_force = 1'b1;
      bus.direction = 2'b11;
      pulse_restart(1'b0);
      wait_read(23'd0, "rst_mid");
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_read", {31'd0, bus.flash_read}, 32'd0);
      chk("async_addr", {9'd0, bus.flash_address}, 32'd0);
      chk("async_data", {16'd0, bus.audio_data}, 32'd0);
      chk("async_valid", {31'd0, bus.audio_valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      wr_force = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
